// File: rtl/font_byte_fetch.sv
// font_byte_fetch: fetches glyph-row bytes from an external character ROM with a one-deep pending slot and timeout fill.
// Define FONT_FETCH_CACHE_EN to add a one-entry tag that serves repeated addresses without a ROM access.
module font_byte_fetch #(
  parameter int TIMEOUT = 16,
  parameter logic [7:0] FILL_BYTE = 8'hFF,
  parameter int CODE_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] charCode,
  input  logic              readEn,
  input  logic [3:0]        addOffset,
  output logic              romReq,
  output logic [CODE_W+3:0] romAddr,
  input  logic              romAck,
  input  logic [7:0]        romData,
  output logic [7:0]        romByte,
  output logic              byteValid,
  output logic              fetchErr,
  output logic              overrun
);
  localparam int AW = CODE_W + 4;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, nextState;
  logic [AW-1:0] reqAddr, pendAddr, nextAddr, nextPendAddr;
  logic [7:0] count;
  logic pendValid, nextPendValid, ackHit, timeoutHit, done, dropReq, cacheHit, idleHit;
`ifdef FONT_FETCH_CACHE_EN
  logic [AW-1:0] tag;
  logic tagValid;
  assign cacheHit = tagValid && tag == reqAddr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      tag <= '0;
      tagValid <= 1'b0;
    end else if (ackHit) begin
      tag <= romAddr;
      tagValid <= 1'b1;
    end
`else
  assign cacheHit = 1'b0;
`endif
  assign reqAddr = {charCode, addOffset};
  assign romReq = state != IDLE;
  assign ackHit = state == WAIT && romAck;
  assign timeoutHit = state == WAIT && !romAck && count == LAST;
  assign done = ackHit || timeoutHit;
  assign idleHit = state == IDLE && readEn && cacheHit;
  always_comb begin
    nextState = state;
    nextAddr = romAddr;
    nextPendValid = pendValid;
    nextPendAddr = pendAddr;
    dropReq = 1'b0;
    if (state == IDLE) begin
      if (readEn && !cacheHit) begin
        nextState = REQ;
        nextAddr = reqAddr;
      end
    end else if (done) begin
      // A request arriving on the exit cycle refills the slot the pending entry just vacated.
      nextState = pendValid || readEn ? REQ : IDLE;
      nextAddr = pendValid ? pendAddr : readEn ? reqAddr : romAddr;
      nextPendValid = pendValid && readEn;
      nextPendAddr = pendValid && readEn ? reqAddr : pendAddr;
    end else begin
      nextState = WAIT;
      if (readEn) begin
        dropReq = pendValid;
        nextPendValid = 1'b1;
        nextPendAddr = pendValid ? pendAddr : reqAddr;
      end
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      romAddr <= '0;
      pendValid <= 1'b0;
      pendAddr <= '0;
      count <= '0;
      romByte <= 8'h00;
      byteValid <= 1'b0;
      fetchErr <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= nextState;
      romAddr <= nextAddr;
      pendValid <= nextPendValid;
      pendAddr <= nextPendAddr;
      count <= state == WAIT ? count + 8'd1 : '0;
      romByte <= ackHit ? romData : timeoutHit ? FILL_BYTE : romByte;
      byteValid <= done || idleHit;
      fetchErr <= fetchErr || timeoutHit;
      overrun <= dropReq;
    end
endmodule

// File: tb/tb_font_byte_fetch.sv
// tb_font_byte_fetch: directed self-checking bench for font_byte_fetch.
module tb_font_byte_fetch;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [6:0] charCode = '0;
  logic readEn = 1'b0;
  logic [3:0] addOffset = '0;
  logic romReq;
  logic [10:0] romAddr;
  logic romAck = 1'b0;
  logic [7:0] romData = '0;
  logic [7:0] romByte;
  logic byteValid, fetchErr, overrun;
  int checks = 0;
  int errors = 0;
  int n;

  font_byte_fetch #(.TIMEOUT(16), .FILL_BYTE(8'hFF), .CODE_W(7)) dut (
    .clock(clock), .reset(reset), .charCode(charCode), .readEn(readEn),
    .addOffset(addOffset), .romReq(romReq), .romAddr(romAddr), .romAck(romAck),
    .romData(romData), .romByte(romByte), .byteValid(byteValid),
    .fetchErr(fetchErr), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [6:0] c, input logic [3:0] o);
    charCode = c;
    addOffset = o;
    readEn = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_req", romReq, 0);
    chk("rst_addr", romAddr, 0);
    chk("rst_byte", romByte, 0);
    chk("rst_valid", byteValid, 0);
    chk("rst_err", fetchErr, 0);
    chk("rst_ovr", overrun, 0);
    tick;
    reset = 1'b1;
    repeat (8) tick;
    // single fetch: readEn at cycle 10, ack at cycle 13
    req(7'h41, 4'h3);
    tick;
    readEn = 1'b0;
    chk("sf_addr", romAddr, 11'h413);
    chk("sf_req11", romReq, 1);
    tick;
    chk("sf_req12", romReq, 1);
    tick;
    chk("sf_req13", romReq, 1);
    chk("sf_nov13", byteValid, 0);
    romAck = 1'b1;
    romData = 8'h3C;
    tick;
    romAck = 1'b0;
    chk("sf_byte", romByte, 8'h3C);
    chk("sf_valid", byteValid, 1);
    chk("sf_reqoff", romReq, 0);
    chk("sf_err", fetchErr, 0);
    tick;
    chk("sf_pulse", byteValid, 0);
    chk("sf_hold", romByte, 8'h3C);
    // back-to-back with pending
    req(7'h12, 4'h5);
    tick;
    readEn = 1'b0;
    chk("bb_addrA", romAddr, 11'h125);
    tick;
    req(7'h2A, 4'hA);
    tick;
    readEn = 1'b0;
    romAck = 1'b1;
    romData = 8'hA5;
    chk("bb_ovr0", overrun, 0);
    tick;
    romAck = 1'b0;
    chk("bb_validA", byteValid, 1);
    chk("bb_byteA", romByte, 8'hA5);
    chk("bb_reqB", romReq, 1);
    chk("bb_addrB", romAddr, 11'h2AA);
    chk("bb_ovr1", overrun, 0);
    tick;
    chk("bb_nov", byteValid, 0);
    tick;
    romAck = 1'b1;
    romData = 8'h5A;
    tick;
    romAck = 1'b0;
    chk("bb_validB", byteValid, 1);
    chk("bb_byteB", romByte, 8'h5A);
    chk("bb_idle", romReq, 0);
    tick;
    // overrun: two extra requests while A is outstanding
    req(7'h01, 4'h1);
    tick;
    req(7'h02, 4'h2);
    tick;
    req(7'h03, 4'h3);
    tick;
    readEn = 1'b0;
    chk("ov_pulse", overrun, 1);
    chk("ov_addrA", romAddr, 11'h011);
    romAck = 1'b1;
    romData = 8'h11;
    tick;
    romAck = 1'b0;
    chk("ov_clear", overrun, 0);
    chk("ov_byteA", romByte, 8'h11);
    chk("ov_addr2", romAddr, 11'h022);
    chk("ov_req2", romReq, 1);
    tick;
    romAck = 1'b1;
    romData = 8'h22;
    tick;
    romAck = 1'b0;
    chk("ov_byte2", romByte, 8'h22);
    chk("ov_done", romReq, 0);
    tick;
    chk("ov_nothird", romReq, 0);
    // readEn coinciding with ack, slot empty
    req(7'h1F, 4'h7);
    tick;
    readEn = 1'b0;
    chk("sim_addr1", romAddr, 11'h1F7);
    tick;
    romAck = 1'b1;
    romData = 8'hC3;
    req(7'h06, 4'h4);
    tick;
    romAck = 1'b0;
    readEn = 1'b0;
    chk("sim_byte1", romByte, 8'hC3);
    chk("sim_valid", byteValid, 1);
    chk("sim_req2", romReq, 1);
    chk("sim_addr2", romAddr, 11'h064);
    chk("sim_ovr", overrun, 0);
    tick;
    romAck = 1'b1;
    romData = 8'h99;
    tick;
    romAck = 1'b0;
    chk("sim_byte2", romByte, 8'h99);
    chk("sim_idle", romReq, 0);
    tick;
    // repeat of the last acked address
    req(7'h06, 4'h4);
    tick;
    readEn = 1'b0;
`ifdef FONT_FETCH_CACHE_EN
    chk("c_noreq", romReq, 0);
    chk("c_valid", byteValid, 1);
    chk("c_byte", romByte, 8'h99);
    tick;
    chk("c_pulse", byteValid, 0);
`else
    chk("nc_req", romReq, 1);
    chk("nc_addr", romAddr, 11'h064);
    chk("nc_novalid", byteValid, 0);
    tick;
    romAck = 1'b1;
    romData = 8'h99;
    tick;
    romAck = 1'b0;
    chk("nc_valid", byteValid, 1);
`endif
    tick;
    // timeout: ROM never acks
    req(7'h55, 4'hF);
    tick;
    readEn = 1'b0;
    n = 0;
    while (romReq && n < 40) begin
      n++;
      tick;
    end
    chk("to_cycles", n, 17);
    chk("to_fill", romByte, 8'hFF);
    chk("to_valid", byteValid, 1);
    chk("to_err", fetchErr, 1);
    tick;
    chk("to_sticky", fetchErr, 1);
    chk("to_pulse", byteValid, 0);
    // reset during WAIT, then a stray ack
    req(7'h33, 4'h3);
    tick;
    readEn = 1'b0;
    tick;
    #1 reset = 1'b0;
    #1;
    chk("mr_req", romReq, 0);
    chk("mr_addr", romAddr, 0);
    chk("mr_byte", romByte, 0);
    chk("mr_err", fetchErr, 0);
    chk("mr_valid", byteValid, 0);
    tick;
    reset = 1'b1;
    romAck = 1'b1;
    romData = 8'h77;
    tick;
    romAck = 1'b0;
    chk("mr_novalid", byteValid, 0);
    chk("mr_noreq", romReq, 0);
    chk("mr_keep", romByte, 0);
    tick;
    chk("mr_novalid2", byteValid, 0);
    chk("mr_noreq2", romReq, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/font_byte_fetch.md
Name: font_byte_fetch

Overview:
- Upstream feeder of the display controller.
- Turns the controller's glyph-row requests (readEn plus a 4-bit row offset) and the current character code into handshaked reads of an external character ROM.
- Holds the returned font byte stable on romByte for the pixel serialiser.
- Absorbs variable ROM latency with a one-deep pending request and substitutes a fill byte on ROM timeout.

Parameters:
- TIMEOUT, 16: max cycles waiting for romAck before abort; legal range 2..255.
- FILL_BYTE, 8'hFF: byte presented when a fetch times out.
- CODE_W, 7: character code width; ROM address width is CODE_W+4.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- charCode  in  CODE_W  character code of the cell being drawn; sampled with readEn.
- readEn  in  1  fetch request strobe from the display controller, one cycle per request.
- addOffset  in  4  glyph row 0..15; sampled with readEn.
- romReq  out  1  ROM read request, level; held until romAck or timeout.
- romAddr  out  CODE_W+4  {charCode, addOffset} of the active fetch; stable while romReq=1.
- romAck  in  1  ROM data-valid strobe, one cycle.
- romData  in  8  ROM read data, valid when romAck=1.
- romByte  out  8  current font byte to the display controller.
- byteValid  out  1  one-cycle pulse when romByte updates.
- fetchErr  out  1  sticky timeout flag; cleared only by reset.
- overrun  out  1  one-cycle pulse when a request is dropped.

Behaviour:
- Reset (reset=0, async) clears all outputs and state:
  - romReq=0, romAddr=0, romByte=8'h00, byteValid=0, fetchErr=0, overrun=0.
  - FSM enters IDLE; pending slot empty; timeout counter 0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on readEn=1, latch {charCode, addOffset} into romAddr and go to REQ. romReq rises on the next edge.
  - REQ: romReq=1 for one cycle, then go to WAIT. Counter loads 0.
  - WAIT: romReq stays 1; counter increments each cycle.
    - romAck=1: romByte<=romData, byteValid pulses on the following cycle, romReq drops.
    - Counter reaches TIMEOUT-1 with no ack: romByte<=FILL_BYTE, byteValid pulses, fetchErr<=1, romReq drops.
    - Exit is to REQ if a pending request exists (its address is loaded into romAddr), otherwise IDLE.
- Latency: readEn in IDLE at cycle N gives romReq=1 at N+1. romAck at cycle M gives romByte/byteValid at M+1. Minimum readEn-to-byte latency is 3 cycles.
- Pending slot (one deep):
  - readEn while in REQ or WAIT stores its address if the slot is empty.
  - If the slot is full, the new request is dropped and overrun pulses. The pending address is unchanged.
- Simultaneous events:
  - readEn in the same cycle as romAck: the ack completes first, then the new request is served. No overrun if the slot was empty.
  - romAck on the timeout cycle: ack wins, no fetchErr.
  - romAck while not in WAIT: ignored.
- romByte holds its value between updates. It is never cleared except by reset.
- Reset mid-fetch drops romReq immediately (asynchronous). Any late romAck after reset release is ignored because the FSM is in IDLE.

Optional Feature:
- Macro: FONT_FETCH_CACHE_EN.
- Defined: adds a one-entry tag register holding the last successfully acked address plus a valid bit.
  - A readEn in IDLE whose {charCode, addOffset} equals the tag skips the ROM: no romReq, romByte is unchanged, and byteValid pulses 1 cycle after readEn.
  - Timeout fills never update the tag.
  - Reset clears the valid bit.
- Not defined: every request goes to the ROM; there is no tag logic.

Test Plan:
- Single fetch:
  - Stimulus: charCode=7'h41, addOffset=4'h3, readEn at cycle 10; ROM acks at cycle 13 with 8'h3C.
  - Required: romAddr=11'h413 at cycle 11; romReq high cycles 11-13; romByte=8'h3C with byteValid at cycle 14; fetchErr=0.
- Timeout:
  - Stimulus: TIMEOUT=16, ROM never acks.
  - Required: romReq falls after 17 high cycles (1 REQ + 16 WAIT); romByte=8'hFF; byteValid pulses; fetchErr=1 and stays 1.
- Back-to-back with pending:
  - Stimulus: request A, then request B during A's WAIT; ROM acks each after 2 cycles.
  - Required: B is issued on the cycle after A's ack, with romAddr=B; two byteValid pulses in order A, B; no overrun.
- Overrun:
  - Stimulus: three readEn pulses while A is outstanding.
  - Required: the second request is stored; the third pulses overrun=1; exactly two further ROM fetches follow.
- Reset during WAIT:
  - Stimulus: assert reset=0 mid-wait, release, then inject a stray romAck.
  - Required: all outputs are 0 immediately; after release, no byteValid and no romReq.
- Cache (FONT_FETCH_CACHE_EN):
  - Stimulus: repeat an address whose fetch was acked.
  - Required: no romReq; byteValid 1 cycle after readEn; romByte unchanged.
